spi_txn_ctrl: RTL and testbench
===============================

Name: spi_txn_ctrl

Overview:
- Transaction sequencer that sits directly upstream of the SPI byte engine (spiModule).
- Accepts one register-access request (read or write, 1..MAX_BYTES data bytes) and frames it under chip select as: command byte, address byte, data bytes.
- Drives the byte engine's start/data_in one byte at a time and collects its done/data_out.
- Returns read data and completion status to the system-side requester.

Parameters:
- MAX_BYTES, 4, maximum data bytes per transaction; sets rdata/wdata width to 8*MAX_BYTES.
- SETUP_CYC, 2, clk cycles from cs_n falling to first byte_start (>=1).
- HOLD_CYC, 2, clk cycles from last byte_done to cs_n rising (>=1).
- GAP_CYC, 4, minimum clk cycles cs_n stays high before ready reasserts (>=1).
- TIMEOUT, 1024, max clk cycles waiting for byte_done before abort (<=65535).
- CMD_RD, 8'h0B, command byte for reads.
- CMD_WR, 8'h0A, command byte for writes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  1  request strobe; accepted when req && ready
- rw  in  1  1 = read, 0 = write
- addr  in  8  register address
- nbytes  in  3  data byte count; 0 treated as 1, >MAX_BYTES clamped to MAX_BYTES
- wdata  in  8*MAX_BYTES  write data; byte k = wdata[8k+7:8k], byte 0 sent first
- ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; 1 = timeout abort
- rdata  out  8*MAX_BYTES  read data; k-th received data byte in rdata[8k+7:8k], unused bytes 0
- cs_n  out  1  SPI chip select, active-low, registered
- byte_start  out  1  one-cycle start pulse to the byte engine
- byte_tx  out  8  byte to transmit, stable from byte_start until byte_done
- byte_done  in  1  byte engine done pulse
- byte_rx  in  8  byte engine received byte, valid with byte_done

Behaviour:
- Reset values (async): state IDLE, cs_n=1, byte_start=0, byte_tx=0, rsp_valid=0, rsp_err=0, rdata=0, all counters 0. ready=1 after reset because it is decoded from IDLE.
- Reset asserted mid-transaction: cs_n goes to 1 immediately, the transaction is dropped, and no rsp_valid is produced.
- States: IDLE, SETUP, SEND, WAIT, HOLD, GAP.
- IDLE:
  - On req: latch rw, addr, wdata and the effective count N (after the 0/clamp rules). Total bytes T = N+2.
  - Clear rdata to 0, clear byte index, drop cs_n to 0, go to SETUP.
  - req while not ready is ignored; no queuing.
- SETUP: count SETUP_CYC cycles with cs_n=0, then go to SEND.
- SEND (exactly 1 cycle):
  - byte_start=1.
  - byte_tx = CMD_RD/CMD_WR for index 0, addr for index 1, else wdata byte (index-2). Reads send 8'h00 in the data phase.
  - Clear the timeout counter, go to WAIT.
- WAIT:
  - On byte_done: if rw=1 and index>=2, store byte_rx into rdata byte (index-2).
  - Then increment the index. If index == T-1, go to HOLD; otherwise go to SEND. Back-to-back bytes therefore have one SEND cycle between done and the next start.
  - If TIMEOUT cycles elapse without byte_done: set the error flag, go to HOLD.
- byte_done seen in any state other than WAIT is ignored.
- HOLD:
  - Count HOLD_CYC cycles with cs_n=0.
  - On exit: cs_n=1, rsp_valid=1 for one cycle, rsp_err = error flag. rdata is held stable until the next accept.
  - Go to GAP.
- GAP: count GAP_CYC cycles with cs_n=1, then go to IDLE (ready=1).
- Writes also pulse rsp_valid; rdata stays 0 for writes.
- Counters are 16-bit with no wrap; a counter only runs in its own state.

Test Plan:
- Read, addr=8'h08, nbytes=1, byte_rx returns 8'hAD on the 3rd done -> byte_tx sequence 0B,08,00; rdata=32'h000000AD; rsp_valid 1 cycle; rsp_err=0; cs_n low from accept+1 through last done+HOLD_CYC.
- Write, addr=8'h1F, nbytes=2, wdata=32'h0000_5A3C -> byte_tx sequence 0A,1F,3C,5A; exactly 4 byte_start pulses; rdata=0; rsp_valid.
- Read, nbytes=0 and nbytes=7 -> exactly 3 and 6 byte_start pulses respectively; nbytes=7 fills rdata with 4 bytes in order.
- byte_done never returns after the first byte_start -> after TIMEOUT=1024 cycles, cs_n rises after HOLD_CYC; rsp_valid with rsp_err=1; ready returns after GAP_CYC.
- rst pulsed during WAIT of the 2nd byte -> cs_n=1 in the same cycle; no rsp_valid; a following req completes normally.
- req held high continuously -> ready low for the whole transaction; the next accept occurs no earlier than GAP_CYC cycles after cs_n rises; a spurious byte_done during GAP is ignored.

Source files
------------

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: frames one register access (command, address, data bytes)
// under chip select. It drives the SPI byte engine one byte at a time and
// returns the read data plus a completion/timeout status to the requester.
module spi_txn_ctrl #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  CMD_RD    = 8'h0B,
  parameter logic [7:0]  CMD_WR    = 8'h0A
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   rw,
  input  logic [7:0]             addr,
  input  logic [2:0]             nbytes,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic                   ready,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   cs_n,
  output logic                   byte_start,
  output logic [7:0]             byte_tx,
  input  logic                   byte_done,
  input  logic [7:0]             byte_rx
);

  localparam int          NB         = int'(MAX_BYTES);
  localparam int          DW         = 8 * NB;
  // nbytes is only 3 bits wide, so the usable data count never exceeds 7.
  localparam logic [3:0]  MAX_N      = (NB > 7) ? 4'd7 : 4'(NB);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SEND, S_WAIT, S_HOLD, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, cnt_inc;
  logic [3:0]      idx_q, idx_d;
  logic            err_q, err_d;
  logic [3:0]      last_q;          // index of the final byte, T-1
  logic [3:0]      n_eff;
  logic            rw_q;
  logic [7:0]      addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            cs_n_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic            accept;
  logic            hold_done;
  logic            rx_store;

  assign accept    = (state_q == S_IDLE) && req;
  assign hold_done = (state_q == S_HOLD) && (cnt_q == HOLD_LAST);
  assign rx_store  = (state_q == S_WAIT) && byte_done && rw_q && (idx_q >= 4'd2);

  // Effective data byte count: 0 means one byte, oversize requests clamp.
  always_comb begin
    n_eff = {1'b0, nbytes};
    if (nbytes == 3'd0) begin
      n_eff = 4'd1;
    end else if ({1'b0, nbytes} > MAX_N) begin
      n_eff = MAX_N;
    end
  end

  // State register: FSM state, shared phase counter, byte index, error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: phase counting, byte sequencing and the done timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req) begin
          state_d = S_SETUP;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (byte_done) begin
          cnt_d   = '0;
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == last_q) ? S_HOLD : S_SEND;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch, read-data capture, chip select and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= hold_done;
      rsp_err_q   <= hold_done & err_q;
      if (accept) begin
        rw_q    <= rw;
        addr_q  <= addr;
        wdata_q <= wdata;
        last_q  <= n_eff + 4'd1;
        rdata_q <= '0;
        cs_n_q  <= 1'b0;
      end
      if (hold_done) begin
        cs_n_q <= 1'b1;
      end
      if (rx_store) begin
        for (int k = 0; k < NB; k++) begin
          if (idx_q == 4'(k + 2)) begin
            rdata_q[8*k +: 8] <= byte_rx;
          end
        end
      end
    end
  end

  // Outputs decoded from state; byte_tx follows the index while a byte is in flight.
  always_comb begin
    ready      = (state_q == S_IDLE);
    byte_start = (state_q == S_SEND);
    byte_tx    = 8'h00;
    if ((state_q == S_SEND) || (state_q == S_WAIT)) begin
      if (idx_q == 4'd0) begin
        byte_tx = rw_q ? CMD_RD : CMD_WR;
      end else if (idx_q == 4'd1) begin
        byte_tx = addr_q;
      end else if (!rw_q) begin
        for (int k = 0; k < NB; k++) begin
          if (idx_q == 4'(k + 2)) begin
            byte_tx = wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rdata     = rdata_q;
  assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: directed bench for spi_txn_ctrl with a behavioural byte
// engine, an expected-byte scoreboard and an expected-response scoreboard.
module tb_spi_txn_ctrl;

  localparam int MAXB     = 4;
  localparam int LAT      = 3;     // engine cycles from byte_start to byte_done
  localparam int HOLD_CYC = 2;
  localparam int GAP_CYC  = 4;
  localparam int TIMEOUT  = 1024;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        rw;
  logic [7:0]  addr;
  logic [2:0]  nbytes;
  logic [31:0] wdata;
  logic        ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rdata;
  logic        cs_n;
  logic        byte_start;
  logic [7:0]  byte_tx;
  logic        byte_done = 1'b0;
  logic [7:0]  byte_rx   = 8'h00;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   n_starts    = 0;
  int   rsp_cnt     = 0;
  int   fall_cyc    = 0;
  int   rise_cyc    = 0;
  int   last_done_cyc = 0;
  logic prev_rsp    = 1'b0;
  logic prev_cs     = 1'b1;
  bit   eng_en      = 1'b1;
  bit   eng_busy    = 1'b0;
  int   eng_left    = 0;
  int   spur_cnt    = 0;
  int   spur_seen   = 0;
  rsp_t mon_r;

  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];
  rsp_t       exp_rsp[$];

  spi_txn_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rw         (rw),
    .addr       (addr),
    .nbytes     (nbytes),
    .wdata      (wdata),
    .ready      (ready),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rdata      (rdata),
    .cs_n       (cs_n),
    .byte_start (byte_start),
    .byte_tx    (byte_tx),
    .byte_done  (byte_done),
    .byte_rx    (byte_rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte engine model: answers each start after LAT cycles, plus injected strays.
  always @(negedge clk) begin
    byte_done = 1'b0;
    if (eng_busy) begin
      eng_left--;
      if (eng_left == 0) begin
        byte_done     = 1'b1;
        byte_rx       = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
        eng_busy      = 1'b0;
        last_done_cyc = cyc;
      end
    end else if (spur_cnt != spur_seen) begin
      spur_seen = spur_cnt;
      byte_done = 1'b1;
      byte_rx   = 8'hE7;
    end
    if (byte_start && eng_en && !rst) begin
      eng_busy = 1'b1;
      eng_left = LAT;
    end
  end

  // Monitor: scoreboard pops on every byte_start and every rsp_valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_start) begin
        n_starts++;
        check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) check("byte_tx", byte_tx, exp_tx.pop_front());
      end
      if (rsp_valid) begin
        rsp_cnt++;
        check("rsp_pulse_width", prev_rsp, 1'b0);
        check("rsp_cs_n", cs_n, 1'b1);
        check("rsp_expected", 64'(exp_rsp.size() != 0), 64'd1);
        if (exp_rsp.size() != 0) begin
          mon_r = exp_rsp.pop_front();
          check("rsp_err", rsp_err, mon_r.err);
          check("rsp_rdata", rdata, mon_r.rdata);
        end
      end
      if (prev_cs && !cs_n) fall_cyc = cyc;
      if (!prev_cs && cs_n) rise_cyc = cyc;
    end
    prev_rsp = rsp_valid;
    prev_cs  = cs_n;
  end

  task automatic wait_ready(input string tag);
    int i = 0;
    while (!ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_ready"}, ready, 1'b1);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int i = 0;
    while (!rsp_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
  endtask

  // One complete transaction with expectations derived from the request.
  task automatic do_txn(input string tag, input logic t_rw, input logic [7:0] t_addr,
                        input logic [2:0] t_nb, input logic [31:0] t_wdata,
                        input logic [31:0] t_rx);
    int          nb_i;
    int          n;
    int          starts0;
    int          rsp0;
    int          acc_cyc;
    logic [31:0] exp_rd;
    rsp_t        r;
    nb_i = int'(t_nb);
    n = (nb_i == 0) ? 1 : ((nb_i > MAXB) ? MAXB : nb_i);
    exp_tx.push_back(t_rw ? 8'h0B : 8'h0A);
    exp_tx.push_back(t_addr);
    rx_q.push_back(8'hC3);
    rx_q.push_back(8'h96);
    exp_rd = '0;
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(t_rw ? 8'h00 : t_wdata[8*k +: 8]);
      rx_q.push_back(t_rx[8*k +: 8]);
      if (t_rw) exp_rd[8*k +: 8] = t_rx[8*k +: 8];
    end
    r.err   = 1'b0;
    r.rdata = exp_rd;
    exp_rsp.push_back(r);
    wait_ready(tag);
    starts0 = n_starts;
    rsp0    = rsp_cnt;
    rw      = t_rw;
    addr    = t_addr;
    nbytes  = t_nb;
    wdata   = t_wdata;
    req     = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
    wait_rsp(tag, 2000);
    @(negedge clk);
    check({tag, "_rsp_count"}, 64'(rsp_cnt - rsp0), 64'd1);
    check({tag, "_starts"}, 64'(n_starts - starts0), 64'(n + 2));
    check({tag, "_cs_fall"}, 64'(fall_cyc), 64'(acc_cyc + 1));
    check({tag, "_cs_rise"}, 64'(rise_cyc), 64'(last_done_cyc + HOLD_CYC + 1));
    repeat (3) @(negedge clk);
    check({tag, "_rdata_held"}, rdata, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   i;
    int   seen;
    int   s0;
    int   rsp0;
    int   s_cyc;
    int   r_cyc;
    int   rdy_hi;
    rsp_t r;

    rst    = 1'b1;
    req    = 1'b0;
    rw     = 1'b0;
    addr   = '0;
    nbytes = '0;
    wdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_byte_start", byte_start, 1'b0);
    check("rst_byte_tx", byte_tx, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready, 1'b1);

    // Basic read, basic write, count 0 and count clamp.
    do_txn("rd1", 1'b1, 8'h08, 3'd1, 32'h0, 32'h0000_00AD);
    do_txn("wr2", 1'b0, 8'h1F, 3'd2, 32'h0000_5A3C, 32'h1122_3344);
    do_txn("rd0", 1'b1, 8'h10, 3'd0, 32'h0, 32'h0000_005E);
    do_txn("rd7", 1'b1, 8'h20, 3'd7, 32'h0, 32'h4433_2211);

    // Engine never answers: timeout abort with rsp_err.
    eng_en = 1'b0;
    exp_tx.push_back(8'h0B);
    r.err   = 1'b1;
    r.rdata = 32'h0;
    exp_rsp.push_back(r);
    wait_ready("to");
    rw     = 1'b1;
    addr   = 8'h22;
    nbytes = 3'd2;
    req    = 1'b1;
    @(negedge clk);
    req = 1'b0;
    i = 0;
    while (!byte_start && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("to_start_seen", byte_start, 1'b1);
    s_cyc = cyc;
    @(negedge clk);
    wait_rsp("to", TIMEOUT + 100);
    r_cyc = cyc;
    check("to_latency", 64'(r_cyc - s_cyc), 64'(1 + TIMEOUT + HOLD_CYC));
    i = 0;
    while (!ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("to_ready_delay", 64'(cyc - r_cyc), 64'(GAP_CYC));
    check("to_cs_rise", 64'(rise_cyc), 64'(r_cyc));
    eng_en = 1'b1;

    // Reset during WAIT of the second byte drops the transaction silently.
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'h1F);
    rx_q.push_back(8'h55);
    rx_q.push_back(8'h66);
    wait_ready("rstmid");
    s0     = n_starts;
    rsp0   = rsp_cnt;
    rw     = 1'b0;
    addr   = 8'h1F;
    nbytes = 3'd2;
    wdata  = 32'h0000_BEEF;
    req    = 1'b1;
    @(negedge clk);
    req  = 1'b0;
    seen = 0;
    i    = 0;
    while (seen < 2 && i < 50) begin
      if (byte_start) seen++;
      @(negedge clk);
      i++;
    end
    check("rstmid_second_start", 64'(seen), 64'd2);
    check("rstmid_pre_cs_n", cs_n, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("rstmid_cs_n", cs_n, 1'b1);
    check("rstmid_ready", ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_rsp", 64'(rsp_cnt - rsp0), 64'd0);
    check("rstmid_starts", 64'(n_starts - s0), 64'd2);
    exp_tx.delete();
    rx_q.delete();
    do_txn("after_rst", 1'b1, 8'h33, 3'd3, 32'h0, 32'h00AB_CDEF);

    // req held high: ready stays low, next accept waits out GAP, stray done ignored.
    for (int t = 0; t < 2; t++) begin
      exp_tx.push_back(8'h0A);
      exp_tx.push_back(8'h40);
      exp_tx.push_back(8'h77);
      rx_q.push_back(8'h01);
      rx_q.push_back(8'h02);
      rx_q.push_back(8'h03);
      r.err   = 1'b0;
      r.rdata = 32'h0;
      exp_rsp.push_back(r);
    end
    wait_ready("gap");
    s0     = n_starts;
    rsp0   = rsp_cnt;
    rw     = 1'b0;
    addr   = 8'h40;
    nbytes = 3'd1;
    wdata  = 32'h0000_0077;
    req    = 1'b1;
    @(negedge clk);
    rdy_hi = 0;
    i      = 0;
    while (!rsp_valid && i < 200) begin
      if (ready) rdy_hi++;
      @(negedge clk);
      i++;
    end
    check("gap_rsp1_seen", rsp_valid, 1'b1);
    check("gap_ready_low", 64'(rdy_hi), 64'd0);
    r_cyc = cyc;
    spur_cnt++;
    i = 0;
    while (!ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("gap_accept_delay", 64'(cyc - r_cyc), 64'(GAP_CYC));
    @(negedge clk);
    req = 1'b0;
    check("gap_busy_after_accept", ready, 1'b0);
    wait_rsp("gap2", 200);
    @(negedge clk);
    check("gap_rsp_count", 64'(rsp_cnt - rsp0), 64'd2);
    check("gap_starts", 64'(n_starts - s0), 64'd6);
    check("gap_rdata", rdata, 32'h0);
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
